// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: gray/binary conversion and pointer types.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int PTR_WIDE_W      = 32;

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;
    typedef logic [PTR_WIDE_W-1:0]    ptr_wide_t;

    // Zero-extended inputs keep both conversions exact for any pointer narrower than 32 bits.
    function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
        ptr_wide_t bin;
        bin = '0;
        for (int i = 0; i < PTR_WIDE_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_prefix
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/occupancy flags of an async FIFO, all in the clk domain.
// Optional sticky overflow flag wovf when ASYNC_FIFO_WOVF_EN is defined.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  almost_full
`ifdef ASYNC_FIFO_WOVF_EN
    ,
    output logic                  wovf
`endif
);

    localparam int             PW     = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]  AF_VAL = PW'(AF_THRESH);

    logic [PW-1:0] wbin_q;
    logic [PW-1:0] wptr_q;
    logic          wfull_q;
    logic [PW-1:0] wcount_q;
    logic          af_q;

    logic          write_ok;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_match;
    logic [PW-1:0] rbin;
    logic [PW-1:0] wcount_next;
    logic          full_next;
    logic          af_next;

    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // A write while full is dropped, so the pointer can never lap the read side.
    assign write_ok    = winc & ~wfull_q;
    assign wbin_next   = wbin_q + PW'(write_ok);
    assign wgray_next  = PW'(bin2gray(ptr_wide_t'(wbin_next)));
    assign full_match  = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    assign full_next   = (wgray_next == full_match);
    assign wcount_next = wbin_next - rbin;
    assign af_next     = (wcount_next >= AF_VAL);

    // NOTE: non-blocking assignments here so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wcount_q <= '0;
            af_q     <= 1'b0;
        end else begin
            wbin_q   <= wbin_next;
            wptr_q   <= wgray_next;
            wfull_q  <= full_next;
            wcount_q <= wcount_next;
            af_q     <= af_next;
        end
    end

`ifdef ASYNC_FIFO_WOVF_EN
    logic wovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wovf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_q | (winc & wfull_q);
        end
    end

    assign wovf = wovf_q;
`endif

    assign waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign wptr        = wptr_q;
    assign wfull       = wfull_q;
    assign wcount      = wcount_q;
    assign almost_full = af_q;

endmodule
